nibble_packer: RTL and testbench
================================

Name: nibble_packer

Overview:
- Serial-to-parallel stage directly upstream of the 3-cycle nibble-destructuring delay pipeline.
- Accepts one nibble per cycle over a valid/ready handshake and packs them MSB-first into one word per `NIBBLES` accepts.
- Presents the word through a one-entry output register, so the pipeline input is fed from a registered source.
- `_i_last` closes a word early and zero-pads the remaining low nibbles.

Parameters:
- NIBBLES, 4, nibbles per output word; legal range 2..8.
- NIBBLE_W, 4, bits per nibble.

Ports:
- _i_clk  input  1  clock; all state updates on the rising edge.
- _i_rst  input  1  synchronous, active-high reset.
- _i_nibble  input  NIBBLE_W  incoming nibble.
- _i_valid  input  1  `_i_nibble` is valid this cycle.
- _i_last  input  1  qualified by `_i_valid`; the accepted nibble closes the current word.
- _o_ready  output  1  the packer accepts a nibble this cycle.
- _o_word  output  NIBBLES*NIBBLE_W  packed word; first accepted nibble in the top field.
- _o_valid  output  1  `_o_word` holds an unconsumed word.
- _i_out_ready  input  1  downstream consumes `_o_word` this cycle when `_o_valid` is high.

Behaviour:
- Reset:
  - Clock and reset are one clock, synchronous reset, active-high.
  - While `_i_rst` is high: `_o_ready`=0, `_o_valid`=0, `_o_word`=0, fill count=0, accumulator=0.
  - Reset mid-word discards partial nibbles.
  - Reset while `_o_valid`=1 drops the pending word.
- State:
  - Fill count `cnt` in 0..NIBBLES-1.
  - Accumulator `acc` of (NIBBLES-1)*NIBBLE_W bits.
  - Output register `{_o_valid, _o_word}`.
- Handshakes:
  - accept = `_i_valid` & `_o_ready`.
  - consume = `_o_valid` & `_i_out_ready`.
- Completing accept: an accept with `cnt`==NIBBLES-1, or with `_i_last`=1.
- Ready rule (combinational, reset aside):
  - `_o_ready` = !(`_o_valid` & !`_i_out_ready`) when the next accept would complete a word.
  - Otherwise `_o_ready` = 1, since non-completing accepts only touch `acc`.
  - No combinational path from `_i_valid` to `_o_ready`.
- Non-completing accept:
  - The nibble is written into field `cnt` of `acc`; field 0 is the most significant.
  - `cnt` increments.
- Completing accept:
  - Next cycle `_o_word` = {acc fields 0..cnt-1, `_i_nibble`, zeros for the remaining fields}.
  - `_o_valid`=1, `cnt`=0, `acc` cleared.
  - Latency: word visible on the cycle after the final nibble is accepted.
- Consume with no completing accept in the same cycle: `_o_valid` falls next cycle; `_o_word` holds its last value.
- Consume and completing accept in the same cycle: the new word replaces the old one, `_o_valid` stays 1, and no bubble is inserted.
- `_i_last` with `cnt`==0: a single-nibble word, e.g. nibble 1 -> 16'h1000.
- `_i_last` on the NIBBLES-th nibble: identical to a normal completion.
- Inputs with `_i_valid`=0 are ignored, including `_i_last`.
- `_o_word` and `_o_valid` are registered outputs.
- Sustained throughput: one nibble per cycle, with zero-stall back-to-back words while `_i_out_ready`=1.

Optional Feature:
- Macro: NIBBLE_PACKER_WORD_COUNT_EN.
- Defined:
  - Adds output `_o_word_count` [15:0], reset to 0.
  - Increments by 1 on each completing accept and wraps 16'hFFFF -> 0.
  - The count is updated in the same cycle the word is loaded into the output register.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset with `_i_valid`=1 held -> `_o_ready`=0, `_o_valid`=0, `_o_word`=0. Release reset -> `_o_ready`=1 on the next cycle.
- Nibbles 1,2,3,4 on consecutive cycles, `_i_out_ready`=1 -> `_o_word`=16'h1234 with `_o_valid`=1 for exactly one cycle, the cycle after the 4th accept.
- Nibble 1 with `_i_last`=1, then nibble 2 with `_i_last`=1 next cycle -> 16'h1000 then 16'h2000 on consecutive cycles. Feeding these to the delay pipeline yields result 1 then 2.
- Backpressure:
  - Word 16'hABCD completes while `_i_out_ready`=0 -> `_o_valid` holds and `_o_word` stays 16'hABCD.
  - Next word's nibbles 5,6,7 are accepted; its 4th nibble sees `_o_ready`=0.
  - Raise `_i_out_ready` -> 16'hABCD is consumed, then 16'h5678 appears.
- Assert `_i_rst` after 2 nibbles (9,8), release, then send 1,2,3,4 -> only 16'h1234 is output; nibbles 9 and 8 never appear.
- NIBBLE_PACKER_WORD_COUNT_EN defined:
  - Three completed words -> `_o_word_count`=3.
  - Preload to 16'hFFFF via a long run, then one more word -> `_o_word_count`=0.

Source files
------------

// File: rtl/nibble_packer.sv
// nibble_packer: serial-to-parallel packer feeding the nibble-destructuring
// delay pipeline. Nibbles arrive over valid/ready, are packed MSB-first into
// one word of NIBBLES fields, and leave through a one-entry output register.
// An accepted nibble with _i_last set closes the word early; the unused low
// fields are zero.
//
// Optional build macro: NIBBLE_PACKER_WORD_COUNT_EN
//   When defined, adds _o_word_count, a 16-bit wrapping count of completed
//   words, updated on the same edge that loads a word into the output register.
module nibble_packer #(
    parameter int NIBBLES  = 4,
    parameter int NIBBLE_W = 4
) (
    input  logic                          _i_clk,
    input  logic                          _i_rst,
    input  logic [NIBBLE_W-1:0]           _i_nibble,
    input  logic                          _i_valid,
    input  logic                          _i_last,
    output logic                          _o_ready,
    output logic [NIBBLES*NIBBLE_W-1:0]   _o_word,
    output logic                          _o_valid,
    input  logic                          _i_out_ready
`ifdef NIBBLE_PACKER_WORD_COUNT_EN
    ,
    output logic [15:0]                   _o_word_count
`endif
);

    localparam int WORD_W = NIBBLES * NIBBLE_W;
    localparam int ACC_W  = (NIBBLES - 1) * NIBBLE_W;
    localparam int CNT_W  = $clog2(NIBBLES);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);

    // Architectural state
    logic [CNT_W-1:0]  r_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic [WORD_W-1:0] r_word;
    logic              r_valid;

    // Combinational helpers
    logic              w_completes_next;
    logic              w_ready;
    logic              w_accept;
    logic              w_consume;
    logic              w_complete;
    logic [WORD_W-1:0] w_word_base;
    logic [WORD_W-1:0] w_word_next;
    logic [ACC_W-1:0]  w_acc_next;

    // Ready: a non-completing accept only touches the accumulator, so it is
    // always safe; a completing accept needs the output register to be free
    // or being drained this cycle. _i_valid deliberately does not feed this.
    always_comb begin
        w_completes_next = (r_cnt == CNT_LAST) | _i_last;
        if (_i_rst) begin
            w_ready = 1'b0;
        end else if (w_completes_next) begin
            w_ready = !(r_valid & !_i_out_ready);
        end else begin
            w_ready = 1'b1;
        end
    end

    assign w_accept   = _i_valid & w_ready;
    assign w_consume  = r_valid & _i_out_ready;
    assign w_complete = w_accept & w_completes_next;

    // Build the next accumulator and the candidate output word by dropping the
    // incoming nibble into field r_cnt (field 0 is the most significant).
    // Fields beyond r_cnt are already zero because acc is cleared per word.
    always_comb begin
        w_word_base = {r_acc, {NIBBLE_W{1'b0}}};
        w_word_next = w_word_base;
        w_acc_next  = r_acc;
        for (int k = 0; k < NIBBLES; k++) begin
            w_word_next[WORD_W-1-k*NIBBLE_W -: NIBBLE_W] =
                (r_cnt == CNT_W'(k)) ? _i_nibble
                                     : w_word_base[WORD_W-1-k*NIBBLE_W -: NIBBLE_W];
        end
        for (int k = 0; k < NIBBLES - 1; k++) begin
            w_acc_next[ACC_W-1-k*NIBBLE_W -: NIBBLE_W] =
                (r_cnt == CNT_W'(k)) ? _i_nibble
                                     : r_acc[ACC_W-1-k*NIBBLE_W -: NIBBLE_W];
        end
    end

    // Fill count, accumulator and output register. A completing accept wins
    // over a same-cycle consume so back-to-back words have no bubble.
    always_ff @(posedge _i_clk) begin
        if (_i_rst) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_acc   <= {ACC_W{1'b0}};
            r_word  <= {WORD_W{1'b0}};
            r_valid <= 1'b0;
        end else if (w_complete) begin
            r_cnt   <= {CNT_W{1'b0}};
            r_acc   <= {ACC_W{1'b0}};
            r_word  <= w_word_next;
            r_valid <= 1'b1;
        end else begin
            if (w_accept) begin
                r_cnt <= r_cnt + CNT_ONE;
                r_acc <= w_acc_next;
            end else begin
                r_cnt <= r_cnt;
                r_acc <= r_acc;
            end
            if (w_consume) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
            r_word <= r_word;
        end
    end

    assign _o_ready = w_ready;
    assign _o_word  = r_word;
    assign _o_valid = r_valid;

`ifdef NIBBLE_PACKER_WORD_COUNT_EN
    logic [15:0] r_word_count;

    // Completed-word counter, wrapping naturally at 16 bits.
    always_ff @(posedge _i_clk) begin
        if (_i_rst) begin
            r_word_count <= 16'd0;
        end else if (w_complete) begin
            r_word_count <= r_word_count + 16'd1;
        end else begin
            r_word_count <= r_word_count;
        end
    end

    assign _o_word_count = r_word_count;
`endif

endmodule

// File: tb/tb_nibble_packer.sv
// Self-checking bench for nibble_packer (NIBBLES=4, NIBBLE_W=4): directed
// vector table, hand-written reset sequences, and randomized traffic against a
// queue-based reference model.
module tb_nibble_packer;

    localparam int NIB = 4;
    localparam int NW  = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  nibble;
    logic        valid;
    logic        last;
    logic        ready;
    logic [15:0] word;
    logic        o_valid;
    logic        out_ready;
`ifdef NIBBLE_PACKER_WORD_COUNT_EN
    logic [15:0] word_count;
`endif

    int n_chk = 0;
    int n_err = 0;

    nibble_packer #(.NIBBLES(NIB), .NIBBLE_W(NW)) dut (
        ._i_clk       (clk),
        ._i_rst       (rst),
        ._i_nibble    (nibble),
        ._i_valid     (valid),
        ._i_last      (last),
        ._o_ready     (ready),
        ._o_word      (word),
        ._o_valid     (o_valid),
        ._i_out_ready (out_ready)
`ifdef NIBBLE_PACKER_WORD_COUNT_EN
        ,
        ._o_word_count(word_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  nib;
        logic        vld;
        logic        lst;
        logic        ordy;
        logic        exp_rdy;
        logic        exp_vld;
        logic [15:0] exp_word;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] n, input logic v, input logic l, input logic o,
                                input logic er, input logic ev, input logic [15:0] ew);
        vec_t x;
        x.nib = n; x.vld = v; x.lst = l; x.ordy = o;
        x.exp_rdy = er; x.exp_vld = ev; x.exp_word = ew;
        return x;
    endfunction

    task automatic drive(input logic [3:0] n, input logic v, input logic l, input logic o);
        nibble = n; valid = v; last = l; out_ready = o;
    endtask

    // one clock: edge then settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        drive(4'hF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < cycles; i++) begin
            tick();
            chk("rst_ready", {63'd0, ready}, 64'd0);
            chk("rst_valid", {63'd0, o_valid}, 64'd0);
            chk("rst_word", {48'd0, word}, 64'd0);
        end
        rst = 1'b0;
        drive(4'h0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("rst_release_ready", {63'd0, ready}, 64'd1);
    endtask

    // reference model state
    int          mq[$];
    logic        m_valid;
    logic [15:0] m_word;

    function automatic logic [15:0] pack(input int q[$]);
        longint w;
        w = 0;
        foreach (q[i]) w = w + (longint'(q[i]) << (NW * (NIB - 1 - i)));
        return w[15:0];
    endfunction

    initial begin
        rst = 1'b1;
        drive(4'h0, 1'b0, 1'b0, 1'b0);
        #1;
        do_reset(2);

        // ---------------- directed table ----------------
        tbl.push_back(mk(4'h1,1,0,1, 1,0,16'h0000));
        tbl.push_back(mk(4'h2,1,0,1, 1,0,16'h0000));
        tbl.push_back(mk(4'h3,1,0,1, 1,0,16'h0000));
        tbl.push_back(mk(4'h4,1,0,1, 1,1,16'h1234));
        tbl.push_back(mk(4'h0,0,0,1, 1,0,16'h1234));
        tbl.push_back(mk(4'h1,1,1,1, 1,1,16'h1000));
        tbl.push_back(mk(4'h2,1,1,1, 1,1,16'h2000));
        tbl.push_back(mk(4'h0,0,0,1, 1,0,16'h2000));
        tbl.push_back(mk(4'hA,1,0,0, 1,0,16'h2000));
        tbl.push_back(mk(4'hB,1,0,0, 1,0,16'h2000));
        tbl.push_back(mk(4'hC,1,0,0, 1,0,16'h2000));
        tbl.push_back(mk(4'hD,1,0,0, 1,1,16'hABCD));
        tbl.push_back(mk(4'h5,1,0,0, 1,1,16'hABCD));
        tbl.push_back(mk(4'h6,1,0,0, 1,1,16'hABCD));
        tbl.push_back(mk(4'h7,1,0,0, 1,1,16'hABCD));
        tbl.push_back(mk(4'h8,1,0,0, 0,1,16'hABCD));
        tbl.push_back(mk(4'h8,1,0,1, 1,1,16'h5678));
        tbl.push_back(mk(4'h0,0,0,1, 1,0,16'h5678));
        tbl.push_back(mk(4'hF,0,1,1, 1,0,16'h5678));
        tbl.push_back(mk(4'h1,1,0,1, 1,0,16'h5678));
        tbl.push_back(mk(4'h2,1,0,1, 1,0,16'h5678));
        tbl.push_back(mk(4'h3,1,0,1, 1,0,16'h5678));
        tbl.push_back(mk(4'h4,1,1,1, 1,1,16'h1234));
        tbl.push_back(mk(4'h9,1,0,1, 1,0,16'h1234));
        tbl.push_back(mk(4'hA,1,0,1, 1,0,16'h1234));
        tbl.push_back(mk(4'hB,1,1,1, 1,1,16'h9AB0));
        tbl.push_back(mk(4'h0,0,0,1, 1,0,16'h9AB0));
        tbl.push_back(mk(4'h7,1,1,0, 1,1,16'h7000));
        tbl.push_back(mk(4'h6,1,1,0, 0,1,16'h7000));
        tbl.push_back(mk(4'h6,1,1,1, 1,1,16'h6000));
        tbl.push_back(mk(4'h0,0,0,1, 1,0,16'h6000));

        foreach (tbl[i]) begin
            drive(tbl[i].nib, tbl[i].vld, tbl[i].lst, tbl[i].ordy);
            #1;
            chk($sformatf("tbl%0d_ready", i), {63'd0, ready}, {63'd0, tbl[i].exp_rdy});
            tick();
            chk($sformatf("tbl%0d_valid", i), {63'd0, o_valid}, {63'd0, tbl[i].exp_vld});
            chk($sformatf("tbl%0d_word", i), {48'd0, word}, {48'd0, tbl[i].exp_word});
        end

        // ---------------- reset mid-word discards 9,8 ----------------
        do_reset(1);
        drive(4'h9, 1'b1, 1'b0, 1'b1); tick();
        drive(4'h8, 1'b1, 1'b0, 1'b1); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        begin
            logic [3:0] seq [4];
            seq[0] = 4'h1; seq[1] = 4'h2; seq[2] = 4'h3; seq[3] = 4'h4;
            for (int i = 0; i < 4; i++) begin
                drive(seq[i], 1'b1, 1'b0, 1'b1);
                tick();
                if (i < 3) chk("midrst_no_word", {63'd0, o_valid}, 64'd0);
            end
        end
        chk("midrst_valid", {63'd0, o_valid}, 64'd1);
        chk("midrst_word", {48'd0, word}, 64'h1234);
        drive(4'h0, 1'b0, 1'b0, 1'b1); tick();
        chk("midrst_once", {63'd0, o_valid}, 64'd0);

        // ---------------- reset drops a pending word ----------------
        drive(4'hE, 1'b1, 1'b1, 1'b0); tick();
        chk("pend_valid", {63'd0, o_valid}, 64'd1);
        chk("pend_word", {48'd0, word}, 64'hE000);
        do_reset(1);

        // ---------------- randomized traffic vs model ----------------
        m_valid = 1'b0;
        m_word  = 16'h0000;
        mq.delete();
        for (int c = 0; c < 3000; c++) begin
            logic r_rst, r_v, r_l, r_o, e_rdy, comp_next, acc;
            logic [3:0] r_n;
            r_rst = ($urandom_range(0, 96) == 0);
            r_v   = ($urandom_range(0, 3) != 0);
            r_l   = ($urandom_range(0, 5) == 0);
            r_o   = ($urandom_range(0, 3) != 0);
            r_n   = 4'($urandom_range(0, 15));
            rst = r_rst;
            drive(r_n, r_v, r_l, r_o);
            comp_next = (mq.size() == NIB - 1) || r_l;
            e_rdy = r_rst ? 1'b0 : !(comp_next && m_valid && !r_o);
            #1;
            chk("rnd_ready", {63'd0, ready}, {63'd0, e_rdy});
            if (r_rst) begin
                mq.delete();
                m_valid = 1'b0;
                m_word  = 16'h0000;
            end else begin
                acc = r_v && e_rdy;
                if (acc) mq.push_back(int'(r_n));
                if (acc && (mq.size() == NIB || r_l)) begin
                    m_word  = pack(mq);
                    m_valid = 1'b1;
                    mq.delete();
                end else if (m_valid && r_o) begin
                    m_valid = 1'b0;
                end
            end
            tick();
            chk("rnd_valid", {63'd0, o_valid}, {63'd0, m_valid});
            chk("rnd_word", {48'd0, word}, {48'd0, m_word});
        end
        rst = 1'b0;

`ifdef NIBBLE_PACKER_WORD_COUNT_EN
        // ---------------- completed-word counter ----------------
        do_reset(1);
        chk("cnt_reset", {48'd0, word_count}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            drive(4'(i + 1), 1'b1, 1'b1, 1'b1);
            tick();
        end
        chk("cnt_three", {48'd0, word_count}, 64'd3);
        for (int i = 0; i < 65532; i++) begin
            drive(4'h5, 1'b1, 1'b1, 1'b1);
            tick();
        end
        chk("cnt_ffff", {48'd0, word_count}, 64'hFFFF);
        drive(4'h5, 1'b1, 1'b1, 1'b1);
        tick();
        chk("cnt_wrap", {48'd0, word_count}, 64'd0);
        drive(4'h0, 1'b0, 1'b0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
